// File: rtl/figure_ram_loader.sv
// Figure bitmap RAM: registered 1-clk read port for the drawer, packetised byte-stream loader on the write side.
// Stream packets: SYNC, index, 256 payload bytes, XOR checksum; each 8-byte line is written as the packet streams in.
module figure_ram_loader #(
  parameter int         NUM_FIGS  = 16,
  parameter int         FIG_AW    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  figure_xy,
  input  logic [4:0]  figure_line,
  output logic [63:0] figure_pixels,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int         DEPTH      = NUM_FIGS * 32;
  localparam logic [8:0] NUM_FIGS_W = 9'(NUM_FIGS);

  typedef enum logic [2:0] {S_IDLE, S_INDEX, S_DATA, S_WRITE, S_CHECK} state_t;

  state_t            state_q, state_d;
  logic [FIG_AW-1:0] idx_q, idx_d;
  logic              idx_bad_q, idx_bad_d;
  logic [7:0]        csum_q, csum_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [4:0]        line_cnt_q, line_cnt_d;
  logic [63:0]       asm_q, asm_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [63:0]       pix_q;
  logic              xfer;
  logic              mem_we;

  logic [63:0] mem [DEPTH];

  assign xfer   = in_valid & rdy_q;
  assign mem_we = (state_q == S_WRITE) && !idx_bad_q && !rst;

  // Nonblocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
    end else if ({1'b0, figure_xy} >= NUM_FIGS_W) begin
      pix_q <= '0;
    end else begin
      pix_q <= mem[{figure_xy[FIG_AW-1:0], figure_line}];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{idx_q, line_cnt_q}] <= asm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      idx_bad_q  <= 1'b0;
      csum_q     <= '0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      asm_q      <= '0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      idx_bad_q  <= idx_bad_d;
      csum_q     <= csum_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      asm_q      <= asm_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    idx_bad_d  = idx_bad_q;
    csum_d     = csum_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d = S_INDEX;
        end
      end
      S_INDEX: begin
        if (xfer) begin
          idx_d      = in_data[FIG_AW-1:0];
          idx_bad_d  = ({1'b0, in_data} >= NUM_FIGS_W);
          csum_d     = in_data;
          byte_cnt_d = '0;
          line_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[55:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        line_cnt_d = line_cnt_q + 5'd1;
        state_d    = (line_cnt_q == 5'd31) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (xfer) begin
          done_d  = (in_data == csum_q) && !idx_bad_q;
          err_d   = !((in_data == csum_q) && !idx_bad_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ready is registered, so it is computed from where the FSM is heading.
    rdy_d = (state_d != S_WRITE);
  end

  assign figure_pixels = pix_q;
  assign in_ready      = rdy_q;
  assign busy          = (state_q != S_IDLE);
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule
